// File: rtl/button_event_decoder.sv
// button_event_decoder
//
// Turns a clean, debounced button level into single-cycle control events for
// the stopwatch FSM. Hold timing is counted in timebase ticks, not raw clocks.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   tick_i     one-clk timebase strobe
//   btn_i      debounced button level, synchronous to clk (1 = pressed)
//   press_o    one-clk pulse when the button is pressed
//   release_o  one-clk pulse when the button is released
//   long_o     one-clk pulse when the hold reaches LONG_TICKS
//   repeat_o   one-clk pulse every REPEAT_TICKS ticks while long-held
//   held_o     level, high while in the long-held state
//
// All outputs are registered. Each pulse appears in the cycle after the
// clock edge that sampled its cause.
module button_event_decoder #(
    parameter int unsigned LONG_TICKS   = 8,
    parameter int unsigned REPEAT_TICKS = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_i,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    typedef enum logic [1:0] {
        StIdle,
        StShort,
        StHeld
    } state_e;

    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_prev_btn;
    logic               r_press;
    logic               r_release;
    logic               r_long;
    logic               r_repeat;
    logic               r_held;

    state_e             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_rise;
    logic               w_press;
    logic               w_release;
    logic               w_long;
    logic               w_repeat;
    logic               w_held;

    assign w_rise = btn_i & ~r_prev_btn;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_press      = 1'b0;
        w_release    = 1'b0;
        w_long       = 1'b0;
        w_repeat     = 1'b0;

        unique case (r_state)
            StIdle: begin
                // A tick coincident with the rise is deliberately ignored here,
                // so counting starts with the first tick after the press.
                if (w_rise) begin
                    w_press      = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = StShort;
                end
            end
            StShort: begin
                if (!btn_i) begin
                    w_release    = 1'b1;
                    w_state_next = StIdle;
                end else if (tick_i) begin
                    if (r_cnt == LongLast) begin
                        w_long       = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = StHeld;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            StHeld: begin
                if (!btn_i) begin
                    w_release    = 1'b1;
                    w_state_next = StIdle;
                end else if (tick_i) begin
                    if (r_cnt == RepeatLast) begin
                        w_repeat   = 1'b1;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase

        // held_o tracks the registered state, so it rises together with long_o.
        w_held = (w_state_next == StHeld);
    end

    always_ff @(posedge clk) begin
        // prev_btn follows btn_i even in reset, so a button held through reset
        // never looks like a fresh press.
        r_prev_btn <= btn_i;
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_held    <= w_held;
        end
    end

    assign press_o   = r_press;
    assign release_o = r_release;
    assign long_o    = r_long;
    assign repeat_o  = r_repeat;
    assign held_o    = r_held;

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the clean, debounced button level from the input conditioning stage and turns it into single-cycle control events for the stopwatch FSM.
- Events are press, release, long-press and auto-repeat.
- Timing for long-press and repeat is counted in ticks from the shared timebase strobe, not in raw clocks.
- Sits between each debounced button and the stopwatch control logic.

Parameters:
- LONG_TICKS, 8, ticks of continuous hold after the press before long_o fires; must be at least 1.
- REPEAT_TICKS, 4, ticks between successive repeat_o pulses once long-press is reached; must be at least 1.
- CNT_W, 8, tick counter width; LONG_TICKS and REPEAT_TICKS must each be ≤ 2^CNT_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- tick_i  input  1  one-clk timebase strobe, for example 100 Hz.
- btn_i  input  1  debounced button level, already synchronous to clk; 1 = pressed.
- press_o  output  1  one-clk pulse when the button is pressed.
- release_o  output  1  one-clk pulse when the button is released.
- long_o  output  1  one-clk pulse when the hold reaches LONG_TICKS.
- repeat_o  output  1  one-clk pulse every REPEAT_TICKS ticks while long-held.
- held_o  output  1  level, high while in the long-held state.

Behaviour:
- Single clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, cnt = 0.
  - press_o, release_o, long_o, repeat_o and held_o all 0.
  - prev_btn is loaded with the current btn_i during reset. A button already held through reset therefore produces no press; the decoder waits for release and a fresh press.
- Edge detection:
  - rise = btn_i & ~prev_btn. prev_btn <= btn_i every clk.
- All outputs are registered.
  - Event pulses are high for exactly one clk.
  - Each pulse appears in the cycle after the clk edge that sampled its cause.
  - Pulses default to 0 every cycle unless set.
- FSM states: IDLE, SHORT, HELD.
  - IDLE:
    - On rise: press_o <= 1, cnt <= 0, go to SHORT.
    - Otherwise stay in IDLE, including btn_i held high with no rise.
  - SHORT:
    - If btn_i == 0: release_o <= 1, go to IDLE. Release takes priority over a same-cycle tick.
    - Else on tick_i: if cnt == LONG_TICKS-1, then long_o <= 1, cnt <= 0, go to HELD; otherwise cnt <= cnt+1.
    - No tick_i: cnt holds.
  - HELD:
    - held_o = 1, registered, asserted in the same cycle long_o is high.
    - If btn_i == 0: release_o <= 1, held_o <= 0, go to IDLE. Release has priority over tick.
    - Else on tick_i: if cnt == REPEAT_TICKS-1, then repeat_o <= 1, cnt <= 0; otherwise cnt <= cnt+1.
- Tick counting:
  - The first tick counted is the first tick_i strictly after the cycle in which rise was detected.
  - A tick coincident with rise is not counted.
- Release and re-press:
  - press_o and release_o are never high in the same cycle.
  - A release followed by a re-press one clk later is legal. It produces release_o, then press_o, on consecutive cycles.
- Mutual exclusion: long_o and repeat_o are never high in the same cycle. The first repeat occurs REPEAT_TICKS ticks after long_o.
- Counter range: cnt never exceeds max(LONG_TICKS, REPEAT_TICKS)-1. No wrap-around is possible.
- Reset mid-operation: rst during SHORT or HELD returns to IDLE next cycle with all outputs 0. No release_o is emitted.
- tick_i has no effect in IDLE.

Test Plan:
- Use LONG_TICKS=4, REPEAT_TICKS=2, CNT_W=4 throughout.
- Short tap: tick_i every 5 clk; btn_i high for 12 clk, then low -> press_o one pulse 1 clk after rise, release_o one pulse 1 clk after fall, long_o/repeat_o/held_o stay 0.
- Long hold: tick_i every clk; btn_i high 12 clk -> press_o, long_o on the 4th tick after press, held_o high from that cycle, repeat_o on ticks 6, 8 and 10, release_o on fall, held_o 0 after.
- Release coincident with tick: in SHORT with cnt=3, drop btn_i on the tick cycle -> release_o=1, long_o=0, state IDLE.
- Held through reset: btn_i=1 during and after rst for 10 clk, tick every clk -> no outputs; then btn_i 0 for 2 clk, 1 again -> press_o exactly once.
- Reset mid-hold: assert rst for 1 clk while held_o=1 -> next cycle all outputs 0, no release_o. Later btn_i fall then rise -> normal press_o.
- Rapid re-press: btn_i 1,0,1 on consecutive clk -> release_o and press_o on consecutive cycles, never overlapping.
